// File: rtl/gate_sequencer.sv
// Operand sequencer and self-checker for the two-input gate datapath.
// Steps (a,b) by button or timer, checks all eight gate results and drives the board LEDs.
module gate_sequencer #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int STEP_CYCLES     = 13500000,
    parameter int SETTLE_CYCLES   = 2,
    parameter bit LED_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode_n,
    input  logic       btn_step_n,
    output logic       gate_a,
    output logic       gate_b,
    input  logic [7:0] gate_res,
    output logic [7:0] leds,
    output logic       auto_mode,
    output logic       mismatch
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(STEP_CYCLES + 1);
    localparam int SE_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] STEP_LAST   = ST_W'(STEP_CYCLES - 1);
    localparam logic [SE_W-1:0] SETTLE_LAST = SE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_CHECK  = 2'd1,
        ST_RUN    = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    // Reference truth table for operands {a,b}
    function automatic logic [7:0] expected_vec(input logic [1:0] ops);
        logic a;
        logic b;
        a = ops[1];
        b = ops[0];
        return {a & b, a | b, a ^ b, ~b, ~a, ~(a & b), ~(a | b), ~(a ^ b)};
    endfunction

    function automatic logic [7:0] led_drive(input logic [7:0] lit);
        return LED_ACTIVE_LOW ? ~lit : lit;
    endfunction

    // Index 0 = mode button, index 1 = step button; deb_r holds 1 = pressed.
    logic [1:0]      sync1_r;
    logic [1:0]      sync2_r;
    logic [1:0]      deb_r;
    logic [1:0]      press_r;
    logic [DB_W-1:0] db_cnt_r [2];
    logic            mode_p_s;
    logic            step_p_s;

    state_t          state_r;
    state_t          state_s;
    logic [SE_W-1:0] settle_cnt_r;
    logic [SE_W-1:0] settle_cnt_s;
    logic [ST_W-1:0] timer_r;
    logic [ST_W-1:0] timer_s;
    logic [1:0]      ops_r;
    logic [1:0]      ops_s;
    logic            auto_r;
    logic            auto_s;
    logic            mism_r;
    logic            mism_s;
    logic [7:0]      leds_r;
    logic [7:0]      leds_s;
    logic [7:0]      exp_s;

    // Synchronise and debounce both buttons; an accepted press emits a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 2'b11;
            sync2_r <= 2'b11;
            deb_r   <= 2'b00;
            press_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            sync1_r <= {btn_step_n, btn_mode_n};
            sync2_r <= sync1_r;
            for (int i = 0; i < 2; i++) begin
                press_r[i] <= 1'b0;
                if (~sync2_r[i] != deb_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        db_cnt_r[i] <= {DB_W{1'b0}};
                        deb_r[i]    <= ~sync2_r[i];
                        press_r[i]  <= ~sync2_r[i];
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
                    end
                end else begin
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end
            end
        end
    end

    assign mode_p_s = press_r[0];
    assign step_p_s = press_r[1];

    // State, counters and all output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= {SE_W{1'b0}};
            timer_r      <= {ST_W{1'b0}};
            ops_r        <= 2'b00;
            auto_r       <= 1'b0;
            mism_r       <= 1'b0;
            leds_r       <= led_drive(8'h00);
        end else begin
            state_r      <= state_s;
            settle_cnt_r <= settle_cnt_s;
            timer_r      <= timer_s;
            ops_r        <= ops_s;
            auto_r       <= auto_s;
            mism_r       <= mism_s;
            leds_r       <= leds_s;
        end
    end

    // Next-state logic: settle, check, step (manual or timed), fault hold.
    always_comb begin
        state_s      = state_r;
        settle_cnt_s = settle_cnt_r;
        timer_s      = timer_r;
        ops_s        = ops_r;
        auto_s       = auto_r;
        mism_s       = mism_r;
        leds_s       = leds_r;
        exp_s        = expected_vec(ops_r);
        case (state_r)
            ST_SETTLE: begin
                if (mode_p_s) begin
                    auto_s  = ~auto_r;
                    timer_s = {ST_W{1'b0}};
                end else begin
                    auto_s  = auto_r;
                end
                if (settle_cnt_r == SETTLE_LAST) begin
                    settle_cnt_s = {SE_W{1'b0}};
                    state_s      = ST_CHECK;
                end else begin
                    settle_cnt_s = settle_cnt_r + 1'b1;
                end
            end
            ST_CHECK: begin
                if (gate_res == exp_s) begin
                    leds_s  = led_drive(gate_res);
                    state_s = ST_RUN;
                end else begin
                    // Light only the bits that disagree with the truth table
                    mism_s  = 1'b1;
                    leds_s  = led_drive(exp_s ^ gate_res);
                    state_s = ST_FAULT;
                end
            end
            ST_RUN: begin
                if (mode_p_s) begin
                    auto_s  = ~auto_r;
                    timer_s = {ST_W{1'b0}};
                end else if (!auto_r) begin
                    if (step_p_s) begin
                        ops_s   = ops_r + 2'd1;
                        state_s = ST_SETTLE;
                    end else begin
                        ops_s   = ops_r;
                    end
                end else if (timer_r == STEP_LAST) begin
                    timer_s = {ST_W{1'b0}};
                    ops_s   = ops_r + 2'd1;
                    state_s = ST_SETTLE;
                end else begin
                    timer_s = timer_r + 1'b1;
                end
            end
            ST_FAULT: begin
                if (step_p_s) begin
                    mism_s  = 1'b0;
                    state_s = ST_SETTLE;
                end else begin
                    mism_s  = mism_r;
                end
            end
            default: begin
                state_s = ST_SETTLE;
            end
        endcase
    end

    assign gate_a    = ops_r[1];
    assign gate_b    = ops_r[0];
    assign leds      = leds_r;
    assign auto_mode = auto_r;
    assign mismatch  = mism_r;

endmodule

// File: tb/tb_gate_sequencer.sv
// Scoreboard bench for gate_sequencer: stimulus queues expected output snapshots,
// a monitor pops one on every visible output change and checks value and spacing.
module tb_gate_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode_n = 1'b1;
    logic       btn_step_n = 1'b1;
    logic       gate_a;
    logic       gate_b;
    logic [7:0] gate_res;
    logic [7:0] leds;
    logic       auto_mode;
    logic       mismatch;
    logic [7:0] fault_mask = 8'h00;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // Behavioural gates block, with an optional forced-bit fault.
    assign gate_res = {gate_a & gate_b, gate_a | gate_b, gate_a ^ gate_b, ~gate_b, ~gate_a,
                       ~(gate_a & gate_b), ~(gate_a | gate_b), ~(gate_a ^ gate_b)} ^ fault_mask;

    gate_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES    (10),
        .SETTLE_CYCLES  (2),
        .LED_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode_n(btn_mode_n),
        .btn_step_n(btn_step_n),
        .gate_a    (gate_a),
        .gate_b    (gate_b),
        .gate_res  (gate_res),
        .leds      (leds),
        .auto_mode (auto_mode),
        .mismatch  (mismatch)
    );

    typedef struct packed {
        logic       a;
        logic       b;
        logic [7:0] l;
        logic       m;
        logic       am;
    } snap_t;

    typedef struct {
        snap_t s;
        int    gap;
        string tag;
    } exp_t;

    exp_t sb_q[$];

    task automatic expect_snap(input string tag, input logic a, input logic b,
                               input logic [7:0] l, input logic m, input logic am,
                               input int gap);
        exp_t e;
        e.s   = {a, b, l, m, am};
        e.gap = gap;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Monitor: every change of the observable outputs must match the queue head.
    snap_t prev_snap = 'x;
    int    cyc = 0;
    int    last_cyc = 0;
    always @(negedge clk) begin
        snap_t cur;
        exp_t  e;
        cyc = cyc + 1;
        cur = {gate_a, gate_b, leds, mismatch, auto_mode};
        if (cur !== prev_snap) begin
            total = total + 1;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_change: got a=%0b b=%0b leds=%h mism=%0b auto=%0b, want no change",
                         cur.a, cur.b, cur.l, cur.m, cur.am);
            end else begin
                e = sb_q.pop_front();
                if (cur !== e.s || (e.gap >= 0 && (cyc - last_cyc) != e.gap)) begin
                    $display("FAIL %s: got a=%0b b=%0b leds=%h mism=%0b auto=%0b gap=%0d, want a=%0b b=%0b leds=%h mism=%0b auto=%0b gap=%0d",
                             e.tag, cur.a, cur.b, cur.l, cur.m, cur.am, cyc - last_cyc,
                             e.s.a, e.s.b, e.s.l, e.s.m, e.s.am, e.gap);
                end else begin
                    passed = passed + 1;
                end
            end
            prev_snap = cur;
            last_cyc  = cyc;
        end
    end

    task automatic press(input bit use_mode, input bit use_step);
        @(negedge clk);
        if (use_mode) btn_mode_n = 1'b0;
        if (use_step) btn_step_n = 1'b0;
        repeat (8) @(negedge clk);
        btn_mode_n = 1'b1;
        btn_step_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        wait_empty(budget);
        repeat (4) @(negedge clk);
        total = total + 1;
        if (sb_q.size() != 0) begin
            $display("FAIL %s: pending expected events=%0d, want 0 (next %s)", tag, sb_q.size(), sb_q[0].tag);
            sb_q.delete();
        end else begin
            passed = passed + 1;
        end
    endtask

    initial begin
        logic [1:0] ops_tab [4];
        logic [7:0] led_tab [4];
        logic [7:0] prev_led;
        int         k;
        ops_tab = '{2'b01, 2'b10, 2'b11, 2'b00};
        led_tab = '{8'h93, 8'h8B, 8'h3E, 8'hE0};

        // 1: reset values, then the first check at operands 00
        expect_snap("reset_values", 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, -1);
        expect_snap("idle_leds", 1'b0, 1'b0, 8'hE0, 1'b0, 1'b0, 5);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drain("t1_drain", 50);

        // 2: four clean step presses, including wrap 11 -> 00
        prev_led = 8'hE0;
        for (int i = 0; i < 4; i++) begin
            expect_snap("manual_ops", ops_tab[i][1], ops_tab[i][0], prev_led, 1'b0, 1'b0, -1);
            expect_snap("manual_leds", ops_tab[i][1], ops_tab[i][0], led_tab[i], 1'b0, 1'b0, 3);
            press(1'b0, 1'b1);
            drain("t2_drain", 50);
            prev_led = led_tab[i];
        end

        // 3: bouncing step button yields exactly one increment
        expect_snap("bounce_ops", 1'b0, 1'b1, 8'hE0, 1'b0, 1'b0, -1);
        expect_snap("bounce_leds", 1'b0, 1'b1, 8'h93, 1'b0, 1'b0, 3);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            btn_step_n = 1'b0;
            repeat (2) @(negedge clk);
            btn_step_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        btn_step_n = 1'b0;
        repeat (8) @(negedge clk);
        btn_step_n = 1'b1;
        repeat (10) @(negedge clk);
        drain("t3_drain", 50);

        // 4: auto scan every 13 cycles, step presses ignored, then back to manual
        expect_snap("auto_on", 1'b0, 1'b1, 8'h93, 1'b0, 1'b1, -1);
        expect_snap("auto_ops10", 1'b1, 1'b0, 8'h93, 1'b0, 1'b1, 10);
        expect_snap("auto_leds10", 1'b1, 1'b0, 8'h8B, 1'b0, 1'b1, 3);
        expect_snap("auto_ops11", 1'b1, 1'b1, 8'h8B, 1'b0, 1'b1, 10);
        expect_snap("auto_leds11", 1'b1, 1'b1, 8'h3E, 1'b0, 1'b1, 3);
        expect_snap("auto_ops00", 1'b0, 1'b0, 8'h3E, 1'b0, 1'b1, 10);
        expect_snap("auto_leds00", 1'b0, 1'b0, 8'hE0, 1'b0, 1'b1, 3);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        wait_empty(200);
        expect_snap("auto_off", 1'b0, 1'b0, 8'hE0, 1'b0, 1'b0, -1);
        btn_mode_n = 1'b0;
        repeat (8) @(negedge clk);
        btn_mode_n = 1'b1;
        repeat (8) @(negedge clk);
        drain("t4_drain", 50);

        // 5: forced xor fault at 00, mode ignored, step re-checks the same pair
        fault_mask = 8'h20;
        expect_snap("fault_reset", 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, -1);
        expect_snap("fault_latch", 1'b0, 1'b0, 8'hDF, 1'b1, 1'b0, 5);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drain("t5_fault_drain", 50);
        press(1'b1, 1'b0);
        drain("t5_mode_ignored", 10);
        fault_mask = 8'h00;
        expect_snap("fault_clear", 1'b0, 1'b0, 8'hDF, 1'b0, 1'b0, -1);
        expect_snap("fault_recheck", 1'b0, 1'b0, 8'hE0, 1'b0, 1'b0, 3);
        press(1'b0, 1'b1);
        drain("t5_drain", 50);

        // 6: simultaneous mode+step, then reset during SETTLE
        expect_snap("both_mode_wins", 1'b0, 1'b0, 8'hE0, 1'b0, 1'b1, -1);
        expect_snap("both_auto_step", 1'b0, 1'b1, 8'hE0, 1'b0, 1'b1, 10);
        expect_snap("midsettle_reset", 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1);
        expect_snap("post_reset_leds", 1'b0, 1'b0, 8'hE0, 1'b0, 1'b0, 4);
        @(negedge clk);
        btn_mode_n = 1'b0;
        btn_step_n = 1'b0;
        k = 0;
        while (gate_b !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 8) begin
                btn_mode_n = 1'b1;
                btn_step_n = 1'b1;
            end
        end
        btn_mode_n = 1'b1;
        btn_step_n = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drain("t6_drain", 50);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t, want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
